// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters:
// round-robin on ties, sequences the read latency, routes read data to its issuer.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [2:0] LAT_C     = 3'(MEM_LAT);

  state_t            state_r;
  logic [2:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              owner_r;
  logic              last_grant_r;

  logic idle_s;
  logic grant_if_s;
  logic grant_d_s;
  logic ret_s;

  // Grant/return decisions; gated by rst_n so reset silences every output at once.
  always_comb begin
    idle_s     = (state_r == IDLE) && rst_n;
    grant_if_s = idle_s && if_req && (!d_req || (last_grant_r == OWN_DATA));
    grant_d_s  = idle_s && d_req && (!if_req || (last_grant_r == OWN_FETCH));
    ret_s      = (state_r == BUSY) && (cnt_r == 3'd1) && rst_n;
  end

  // Memory port drive, handshakes and read-data routing.
  always_comb begin
    if_ready       = grant_if_s;
    d_ready        = grant_d_s;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (grant_if_s) begin
      mem_addr = if_addr;
    end else if (grant_d_s) begin
      mem_addr     = d_addr;
      mem_write_en = d_we;
      if (d_we) begin
        mem_write_data = d_wdata;
      end else begin
        mem_write_data = '0;
      end
    end else if ((state_r == BUSY) && rst_n) begin
      mem_addr = addr_r;
    end else begin
      mem_addr = '0;
    end

    if_rvalid = ret_s && (owner_r == OWN_FETCH);
    d_rvalid  = ret_s && (owner_r == OWN_DATA);
    if (if_rvalid) begin
      if_rdata = mem_read_data;
    end else begin
      if_rdata = '0;
    end
    if (d_rvalid) begin
      d_rdata = mem_read_data;
    end else begin
      d_rdata = '0;
    end
  end

  // State, latency counter, latched address/owner and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      addr_r       <= '0;
      owner_r      <= OWN_FETCH;
      last_grant_r <= OWN_DATA;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            addr_r       <= if_addr;
            owner_r      <= OWN_FETCH;
            last_grant_r <= OWN_FETCH;
            cnt_r        <= LAT_C;
            state_r      <= BUSY;
          end else if (grant_d_s) begin
            last_grant_r <= OWN_DATA;
            if (!d_we) begin
              addr_r  <= d_addr;
              owner_r <= OWN_DATA;
              cnt_r   <= LAT_C;
              state_r <= BUSY;
            end else begin
              cnt_r <= 3'd0;
            end
          end else begin
            cnt_r <= 3'd0;
          end
        end
        BUSY: begin
          // A zero count can only come from corruption; fall back to IDLE.
          if (cnt_r <= 3'd1) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: four instances (MEM_LAT 1..4), each with its own
// memory model; directed stimulus queues expected events, a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int NDUT = 4;
  localparam int K_IFR = 0;
  localparam int K_DR  = 1;
  localparam int K_IFV = 2;
  localparam int K_DV  = 3;
  localparam int K_WE  = 4;

  typedef struct {
    int          dut;
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];

  logic        if_req[NDUT];
  logic [31:0] if_addr[NDUT];
  logic        if_ready[NDUT];
  logic        if_rvalid[NDUT];
  logic [31:0] if_rdata[NDUT];
  logic        d_req[NDUT];
  logic        d_we[NDUT];
  logic [31:0] d_addr[NDUT];
  logic [31:0] d_wdata[NDUT];
  logic        d_ready[NDUT];
  logic        d_rvalid[NDUT];
  logic [31:0] d_rdata[NDUT];
  logic        mem_write_en[NDUT];
  logic [31:0] mem_addr[NDUT];
  logic [31:0] mem_write_data[NDUT];
  logic [31:0] mem_read_data[NDUT];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten words read as a fixed address pattern; word 0x100 holds an instruction.
  function automatic logic [31:0] dflt(input logic [7:0] i);
    if (i == 8'd64) return 32'h0050_0093;
    return {8'hC0, i, 8'h5A, ~i};
  endfunction

  function automatic string knm(input int k);
    case (k)
      0: return "if_ready";
      1: return "d_ready";
      2: return "if_rvalid";
      3: return "d_rvalid";
      default: return "mem_write_en";
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [31:0]  arr[256];
    logic [255:0] wr_mask;
    logic [31:0]  pipe[4];
    logic [31:0]  rd_now;
    logic [7:0]   idx;

    assign idx    = mem_addr[g][9:2];
    assign rd_now = wr_mask[idx] ? arr[idx] : dflt(idx);

    // Memory model: write at the edge, read data appears g+1 cycles after the address.
    always @(posedge clk) begin
      if (mem_clr) begin
        wr_mask <= '0;
      end else if (mem_write_en[g]) begin
        arr[idx]     <= mem_write_data[g];
        wr_mask[idx] <= 1'b1;
      end
      pipe[0] <= rd_now;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_read_data[g] = pipe[g];

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(g + 1)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req        (if_req[g]),
      .if_addr       (if_addr[g]),
      .if_ready      (if_ready[g]),
      .if_rvalid     (if_rvalid[g]),
      .if_rdata      (if_rdata[g]),
      .d_req         (d_req[g]),
      .d_we          (d_we[g]),
      .d_addr        (d_addr[g]),
      .d_wdata       (d_wdata[g]),
      .d_ready       (d_ready[g]),
      .d_rvalid      (d_rvalid[g]),
      .d_rdata       (d_rdata[g]),
      .mem_write_en  (mem_write_en[g]),
      .mem_addr      (mem_addr[g]),
      .mem_write_data(mem_write_data[g]),
      .mem_read_data (mem_read_data[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h required=%h", nm, cyc, got, req);
    end
  endtask

  task automatic expect_ev(input int d, input int k, input int c, input logic [31:0] v);
    exp_q.push_back('{dut: d, kind: k, cyc: c, val: v});
  endtask

  task automatic compare_ev(input int d, input int k, input logic [31:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected dut=%0d %s cyc=%0d got=%h required=none", d, knm(k), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || e.cyc != cyc || e.val !== v) begin
        bad++;
        $display("FAIL event got dut=%0d %s cyc=%0d val=%h required dut=%0d %s cyc=%0d val=%h",
                 d, knm(k), cyc, v, e.dut, knm(e.kind), e.cyc, e.val);
      end
    end
  endtask

  // Monitor: every handshake, response or write the DUTs present is matched in order.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (if_ready[d])     compare_ev(d, K_IFR, mem_addr[d]);
      if (d_ready[d])      compare_ev(d, K_DR, mem_addr[d]);
      if (if_rvalid[d]) begin
        compare_ev(d, K_IFV, if_rdata[d]);
        chk("d_rdata_nonowner", d_rdata[d], 32'h0);
      end
      if (d_rvalid[d]) begin
        compare_ev(d, K_DV, d_rdata[d]);
        chk("if_rdata_nonowner", if_rdata[d], 32'h0);
      end
      if (mem_write_en[d]) compare_ev(d, K_WE, mem_write_data[d]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      if_req[d]  = 1'b1;
      if_addr[d] = 32'h0000_0100;
      d_req[d]   = 1'b1;
      d_we[d]    = 1'b1;
      d_addr[d]  = 32'h0000_0200;
      d_wdata[d] = 32'h1111_2222;
    end
    tick();
    tick();
    // Reset state: requests present but nothing may be offered or driven.
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_ready", {30'h0, if_ready[d], d_ready[d]}, 32'h0);
      chk("rst_mem_addr", mem_addr[d], 32'h0);
      chk("rst_mem_we", {31'h0, mem_write_en[d]}, 32'h0);
      chk("rst_mem_wdata", mem_write_data[d], 32'h0);
      if_req[d] = 1'b0;
      d_req[d]  = 1'b0;
      d_we[d]   = 1'b0;
    end
    @(negedge clk);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    tick();
    chk("idle_mem_addr", mem_addr[0], 32'h0);
    chk("idle_ready", {30'h0, if_ready[0], d_ready[0]}, 32'h0);

    // Single fetch at latency 1, then a second fetch accepted two cycles later.
    tick();
    t = cyc;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0100;
    expect_ev(0, K_IFR, t,     32'h0000_0100);
    expect_ev(0, K_IFV, t + 1, 32'h0050_0093);
    expect_ev(0, K_IFR, t + 2, 32'h0000_0104);
    expect_ev(0, K_IFV, t + 3, dflt(8'd65));
    tick();
    if_addr[0] = 32'h0000_0104;
    tick();
    tick();
    if_req[0] = 1'b0;
    tick();

    // Store then load of the same word; only the store raises mem_write_en.
    tick();
    t = cyc;
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h0000_0200;
    d_wdata[0] = 32'hDEAD_BEEF;
    expect_ev(0, K_DR, t,     32'h0000_0200);
    expect_ev(0, K_WE, t,     32'hDEAD_BEEF);
    expect_ev(0, K_DR, t + 1, 32'h0000_0200);
    expect_ev(0, K_DV, t + 2, 32'hDEAD_BEEF);
    tick();
    d_we[0] = 1'b0;
    tick();
    d_req[0] = 1'b0;
    tick();
    tick();

    // Continuous tie at latency 2 after reset: F at 0, D at 3, F at 6.
    do_reset();
    tick();
    t = cyc;
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h0000_0104;
    d_req[1]   = 1'b1;
    d_we[1]    = 1'b0;
    d_addr[1]  = 32'h0000_0208;
    expect_ev(1, K_IFR, t,     32'h0000_0104);
    expect_ev(1, K_IFV, t + 2, dflt(8'd65));
    expect_ev(1, K_DR,  t + 3, 32'h0000_0208);
    expect_ev(1, K_DV,  t + 5, dflt(8'd130));
    expect_ev(1, K_IFR, t + 6, 32'h0000_0104);
    expect_ev(1, K_IFV, t + 8, dflt(8'd65));
    repeat (7) tick();
    if_req[1] = 1'b0;
    d_req[1]  = 1'b0;
    repeat (4) tick();

    // Latency 4 load: address held, no ready while busy, next fetch at N+5.
    t = cyc;
    d_req[3]  = 1'b1;
    d_we[3]   = 1'b0;
    d_addr[3] = 32'h0000_0300;
    expect_ev(3, K_DR,  t,     32'h0000_0300);
    expect_ev(3, K_DV,  t + 4, dflt(8'd192));
    expect_ev(3, K_IFR, t + 5, 32'h0000_0100);
    expect_ev(3, K_IFV, t + 9, 32'h0050_0093);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        d_req[3]   = 1'b0;
        if_req[3]  = 1'b1;
        if_addr[3] = 32'h0000_0100;
      end
      @(negedge clk);
      chk("lat4_mem_addr", mem_addr[3], 32'h0000_0300);
      if (k > 0) chk("lat4_busy_ready", {30'h0, if_ready[3], d_ready[3]}, 32'h0);
      tick();
    end
    tick();
    if_req[3] = 1'b0;
    repeat (5) tick();

    // Reset in cycle 1 of a latency 3 fetch: pending read discarded, reissue accepted.
    t = cyc;
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h0000_0100;
    expect_ev(2, K_IFR, t, 32'h0000_0100);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_addr", mem_addr[2], 32'h0);
    chk("midrst_ready", {30'h0, if_ready[2], d_ready[2]}, 32'h0);
    chk("midrst_rvalid", {30'h0, if_rvalid[2], d_rvalid[2]}, 32'h0);
    repeat (4) tick();
    chk("midrst_hold_ready", {31'h0, if_ready[2]}, 32'h0);
    rst_n = 1'b1;
    t = cyc;
    expect_ev(2, K_IFR, t,     32'h0000_0100);
    expect_ev(2, K_IFV, t + 3, 32'h0050_0093);
    tick();
    if_req[2] = 1'b0;
    repeat (5) tick();

    // Fetch sets last_grant=FETCH; a store/fetch tie then goes to the store.
    t = cyc;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_0108;
    expect_ev(0, K_IFR, t,     32'h0000_0108);
    expect_ev(0, K_IFV, t + 1, dflt(8'd66));
    expect_ev(0, K_DR,  t + 2, 32'h0000_020C);
    expect_ev(0, K_WE,  t + 2, 32'h1234_5678);
    expect_ev(0, K_IFR, t + 3, 32'h0000_010C);
    expect_ev(0, K_IFV, t + 4, dflt(8'd67));
    expect_ev(0, K_DR,  t + 5, 32'h0000_020C);
    expect_ev(0, K_DV,  t + 6, 32'h1234_5678);
    tick();
    if_req[0] = 1'b0;
    tick();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h0000_010C;
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h0000_020C;
    d_wdata[0] = 32'h1234_5678;
    tick();
    d_req[0] = 1'b0;
    d_we[0]  = 1'b0;
    tick();
    if_req[0] = 1'b0;
    tick();
    d_req[0] = 1'b1;
    tick();
    d_req[0] = 1'b0;
    repeat (4) tick();

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
